// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the R-type (OP-class) encode/decode path:
// opcode, func3/func7 field values and the ALU control codes used by the decoder.
package riscv_pkg;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    localparam logic [2:0] FUNC3_ADD_SUB = 3'd0;
    localparam logic [2:0] FUNC3_SLL     = 3'd1;
    localparam logic [2:0] FUNC3_SLT     = 3'd2;
    localparam logic [2:0] FUNC3_SLTU    = 3'd3;
    localparam logic [2:0] FUNC3_XOR     = 3'd4;
    localparam logic [2:0] FUNC3_SRL_SRA = 3'd5;
    localparam logic [2:0] FUNC3_OR      = 3'd6;
    localparam logic [2:0] FUNC3_AND     = 3'd7;

    localparam logic [6:0] FUNC7_BASE = 7'h00;
    localparam logic [6:0] FUNC7_ALT  = 7'h20;

    // ALU control codes shared with the decoder; codes 10..31 are unmapped.
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    typedef struct packed {
        logic [6:0] func7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] func3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rtype_word_t;

endpackage

// File: rtl/rtype_field_pack.sv
// Combinational packer: ALU control code plus register indices -> RV32I R-type word.
module rtype_field_pack
    import riscv_pkg::*;
(
    input  logic [4:0]  alu_control,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic        illegal
);

    logic [2:0]  func3;
    logic [6:0]  func7;
    rtype_word_t fields;

    // Map the ALU code to func3/func7; unmapped codes raise illegal.
    always_comb begin
        func3   = FUNC3_ADD_SUB;
        func7   = FUNC7_BASE;
        illegal = 1'b0;
        case (alu_control)
            ALU_ADD:  func3 = FUNC3_ADD_SUB;
            ALU_SUB:  begin func3 = FUNC3_ADD_SUB; func7 = FUNC7_ALT; end
            ALU_SLL:  func3 = FUNC3_SLL;
            ALU_SLT:  func3 = FUNC3_SLT;
            ALU_SLTU: func3 = FUNC3_SLTU;
            ALU_XOR:  func3 = FUNC3_XOR;
            ALU_SRL:  func3 = FUNC3_SRL_SRA;
            ALU_SRA:  begin func3 = FUNC3_SRL_SRA; func7 = FUNC7_ALT; end
            ALU_OR:   func3 = FUNC3_OR;
            ALU_AND:  func3 = FUNC3_AND;
            default:  illegal = 1'b1;
        endcase
    end

    // Assemble the instruction word from its fields.
    always_comb begin
        fields.func7  = func7;
        fields.rs2    = rs2;
        fields.rs1    = rs1;
        fields.func3  = func3;
        fields.rd     = rd;
        fields.opcode = OPCODE_OP;
        word          = fields;
    end

endmodule

// File: rtl/rtype_inst_encoder.sv
// R-type instruction encoder: accepts encode requests, buffers encoded words in a
// small FIFO and writes them to consecutive imem addresses within a wrapping window.
module rtype_inst_encoder
    import riscv_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          NUM_WORDS  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  alu_control,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ready,
    output logic        err_illegal,
    output logic [15:0] words_written
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [31:0]   LAST_ADDR = BASE_ADDR + 32'((NUM_WORDS - 1) * 4);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rdy_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        accept;
    logic        push;
    logic        pop;

    rtype_field_pack u_pack (
        .alu_control (alu_control),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .word        (enc_word),
        .illegal     (enc_illegal)
    );

    // Handshake and write-port qualifiers; in_ready depends only on registered state and flush.
    always_comb begin
        in_ready   = rdy_q & (count < DEPTH_C) & ~flush;
        accept     = in_valid & in_ready;
        push       = accept & ~enc_illegal;
        imem_we    = (count != '0);
        pop        = imem_we & imem_ready;
        imem_wdata = imem_we ? mem[rd_ptr] : 32'h0;
    end

    // FIFO storage and pointers; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 32'h0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address window, write statistics, illegal-code pulse and post-reset ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q         <= 1'b0;
            imem_addr     <= BASE_ADDR;
            words_written <= 16'h0;
            err_illegal   <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            err_illegal <= accept & enc_illegal;
            if (flush) begin
                imem_addr     <= BASE_ADDR;
                words_written <= 16'h0;
            end else if (pop) begin
                imem_addr <= (imem_addr == LAST_ADDR) ? BASE_ADDR : imem_addr + 32'd4;
                if (words_written != 16'hFFFF) words_written <= words_written + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rtype_inst_encoder.sv
// Self-checking bench for rtype_inst_encoder: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_rtype_inst_encoder;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          NW    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_control = 5'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready = 1'b0;
    logic        err_illegal;
    logic [15:0] words_written;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_addr;
    int          m_words;
    bit          m_err;
    bit          m_rdy;

    rtype_inst_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_control   (alu_control),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_ready    (imem_ready),
        .err_illegal   (err_illegal),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction word from the ISA tables: func3 per operation, func7=0x20 for SUB/SRA.
    function automatic logic [31:0] ref_enc(input int op, input int r_d, input int r_s1,
                                            input int r_s2, output bit ill);
        int f3_tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int f7;
        int f3;
        ill = (op > 9);
        if (ill) return 32'h0;
        f3 = f3_tab[op];
        f7 = (op == 1 || op == 7) ? 32 : 0;
        return 32'(f7 * 33554432 + r_s2 * 1048576 + r_s1 * 32768 + f3 * 4096 + r_d * 128 + 51);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr  = BASE;
        m_words = 0;
        m_err   = 1'b0;
        m_rdy   = 1'b0;
    endtask

    task automatic check_outputs();
        check_val("imem_we", {31'b0, imem_we}, {31'b0, (mq.size() != 0)});
        check_val("imem_addr", imem_addr, m_addr);
        check_val("imem_wdata", imem_wdata, (mq.size() != 0) ? mq[0] : 32'h0);
        check_val("err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
        check_val("words_written", {16'b0, words_written}, 32'(m_words));
    endtask

    // One clock: apply inputs, check outputs against the model, advance model and DUT.
    task automatic cyc(input bit v, input int op, input int r_d, input int r_s1, input int r_s2,
                       input bit mrdy, input bit fl);
        bit          exp_rdy;
        bit          acc;
        bit          pop;
        bit          ill;
        logic [31:0] w;
        in_valid    = v;
        alu_control = 5'(op);
        rd          = 5'(r_d);
        rs1         = 5'(r_s1);
        rs2         = 5'(r_s2);
        imem_ready  = mrdy;
        flush       = fl;
        #1;
        exp_rdy = m_rdy && (mq.size() < DEPTH) && !fl;
        check_val("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        check_outputs();
        acc = v && exp_rdy;
        pop = (mq.size() != 0) && mrdy;
        w   = ref_enc(op, r_d, r_s1, r_s2, ill);
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_addr  = BASE;
            m_words = 0;
            m_err   = 1'b0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_addr  = (m_addr == BASE + 32'((NW - 1) * 4)) ? BASE : m_addr + 32'd4;
                m_words = (m_words < 65535) ? m_words + 1 : 65535;
            end
            m_err = acc && ill;
            if (acc && !ill) mq.push_back(w);
        end
        m_rdy = 1'b1;
    endtask

    task automatic idle(input bit mrdy);
        cyc(1'b0, 0, 0, 0, 0, mrdy, 1'b0);
    endtask

    // Assert reset (asynchronously, mid-cycle), check reset values, release before a rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        check_val("rst_in_ready", {31'b0, in_ready}, 32'h0);
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hold_in_ready", {31'b0, in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_rdy = 1'b1;
        check_val("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    endtask

    initial begin
        model_reset();
        #3;
        do_reset();

        // ADD x3,x1,x2 then word visible next cycle
        cyc(1'b1, ALU_ADD, 3, 1, 2, 1'b1, 1'b0);
        check_val("add_word", imem_wdata, 32'h002081B3);
        check_val("add_addr", imem_addr, BASE);
        idle(1'b1);

        // SUB then SRA from a fresh reset
        do_reset();
        cyc(1'b1, ALU_SUB, 5, 6, 7, 1'b1, 1'b0);
        check_val("sub_word", imem_wdata, 32'h407302B3);
        cyc(1'b1, ALU_SRA, 1, 2, 3, 1'b1, 1'b0);
        check_val("sra_word", imem_wdata, 32'h403150B3);
        check_val("sra_addr", imem_addr, BASE + 32'd4);
        idle(1'b1);

        // Stall: 3 requests against a blocked memory, then drain
        for (int i = 0; i < 5; i++)
            cyc(i < 3, (i == 0) ? 0 : (i == 1) ? 5 : 9, i + 1, i + 2, i + 3, 1'b0, 1'b0);
        check_val("stall_full_ready", {31'b0, in_ready}, 32'h0);
        repeat (3) idle(1'b1);

        // Window wrap: 5 ANDs with all registers x31
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, ALU_AND, 31, 31, 31, 1'b1, 1'b0);
        repeat (2) idle(1'b1);
        check_val("wrap_count", {16'b0, words_written}, 32'd5);
        check_val("wrap_addr", imem_addr, BASE + 32'd4);

        // Unmapped code between two ADDs
        do_reset();
        cyc(1'b1, ALU_ADD, 1, 2, 3, 1'b1, 1'b0);
        cyc(1'b1, 20, 1, 2, 3, 1'b1, 1'b0);
        check_val("illegal_pulse", {31'b0, err_illegal}, 32'h1);
        cyc(1'b1, ALU_ADD, 4, 5, 6, 1'b1, 1'b0);
        repeat (2) idle(1'b1);
        check_val("illegal_count", {16'b0, words_written}, 32'd2);

        // Flush with two words queued and memory stalled
        cyc(1'b1, ALU_OR, 7, 8, 9, 1'b0, 1'b0);
        cyc(1'b1, ALU_XOR, 10, 11, 12, 1'b0, 1'b0);
        cyc(1'b1, ALU_SLT, 1, 1, 1, 1'b0, 1'b1);
        check_val("flush_we", {31'b0, imem_we}, 32'h0);
        check_val("flush_addr", imem_addr, BASE);

        // Reset mid-stall
        cyc(1'b1, ALU_SLL, 2, 3, 4, 1'b0, 1'b0);
        cyc(1'b1, ALU_SRL, 5, 6, 7, 1'b0, 1'b0);
        do_reset();
        check_val("rst_stall_we", {31'b0, imem_we}, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7), int'($urandom_range(0, 13)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 99) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
